// File: rtl/pcpu.sv
// pcpu: single-clock accumulator CPU with a req/ack memory port.
// Optional CALL/RET hardware stack enabled by defining PCPU_STACK_EN.
module pcpu #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted
);

  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_LDB = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_STA = 8'h05;
  localparam logic [7:0] OP_OUT = 8'h06;
  localparam logic [7:0] OP_JMP = 8'h07;
  localparam logic [7:0] OP_JEZ = 8'h08;
  localparam logic [7:0] OP_JNZ = 8'h09;
  localparam logic [7:0] OP_JC  = 8'h0A;
  localparam logic [7:0] OP_HLT = 8'h0F;
`ifdef PCPU_STACK_EN
  localparam logic [7:0] OP_CALL = 8'h0B;
  localparam logic [7:0] OP_RET  = 8'h0C;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPND, S_MEM, S_JUMP, S_PUSH, S_POP, S_HALT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] a, b;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] pc, addr;
  logic              z, c;
`ifdef PCPU_STACK_EN
  logic [ADDR_W-1:0] sp;
`endif

  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W:0]   sum, diff;
  logic              take;

  assign pc_inc = pc + ADDR_ONE;
  // Extra top bit holds ADD carry-out / SUB borrow.
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};

  // Branch condition for the jump opcode held in IR.
  always_comb begin
    take = 1'b0;
    case (ir)
      OP_JMP:  take = 1'b1;
      OP_JEZ:  take = z;
      OP_JNZ:  take = ~z;
      OP_JC:   take = c;
      default: take = 1'b0;
    endcase
  end

  // Control FSM, datapath and registered memory/output ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      a         <= '0;
      b         <= '0;
      ir        <= '0;
      pc        <= '0;
      addr      <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
`ifdef PCPU_STACK_EN
      sp        <= '1;
`endif
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // A completed access drops the request unless a new one is issued below.
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir    <= mem_rdata[7:0];
            pc    <= pc_inc;
            state <= S_DECODE;
            if (mem_rdata[7:0] == OP_OUT) begin
              out_valid <= 1'b1;
              out_data  <= a;
            end
          end
        end
        S_DECODE: begin
          case (ir)
            OP_LDA, OP_LDB, OP_STA, OP_JMP, OP_JEZ, OP_JNZ, OP_JC
`ifdef PCPU_STACK_EN
            , OP_CALL
`endif
            : begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
              state    <= S_OPND;
            end
            OP_ADD: begin
              a        <= sum[DATA_W-1:0];
              c        <= sum[DATA_W];
              z        <= (sum[DATA_W-1:0] == '0);
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
              state    <= S_FETCH;
            end
            OP_SUB: begin
              a        <= diff[DATA_W-1:0];
              c        <= diff[DATA_W];
              z        <= (diff[DATA_W-1:0] == '0);
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
              state    <= S_FETCH;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
`ifdef PCPU_STACK_EN
            OP_RET: begin
              sp       <= sp + ADDR_ONE;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= sp + ADDR_ONE;
              state    <= S_POP;
            end
`endif
            default: begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
              state    <= S_FETCH;
            end
          endcase
        end
        S_OPND: begin
          if (mem_req && mem_ack) begin
            addr <= ADDR_W'(mem_rdata);
            pc   <= pc_inc;
            case (ir)
              OP_LDA, OP_LDB: begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= ADDR_W'(mem_rdata);
                state    <= S_MEM;
              end
              OP_STA: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= ADDR_W'(mem_rdata);
                mem_wdata <= a;
                state     <= S_MEM;
              end
`ifdef PCPU_STACK_EN
              OP_CALL: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= sp;
                mem_wdata <= DATA_W'(pc_inc);
                state     <= S_PUSH;
              end
`endif
              default: state <= S_JUMP;
            endcase
          end
        end
        S_MEM: begin
          if (mem_req && mem_ack) begin
            if (ir == OP_LDA) begin
              a <= mem_rdata;
              z <= (mem_rdata == '0);
            end else if (ir == OP_LDB) begin
              b <= mem_rdata;
            end
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
        end
        S_JUMP: begin
          if (take) pc <= addr;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= take ? addr : pc;
          state    <= S_FETCH;
        end
`ifdef PCPU_STACK_EN
        S_PUSH: begin
          if (mem_req && mem_ack) begin
            sp       <= sp - ADDR_ONE;
            pc       <= addr;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr;
            state    <= S_FETCH;
          end
        end
        S_POP: begin
          if (mem_req && mem_ack) begin
            pc       <= ADDR_W'(mem_rdata);
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= ADDR_W'(mem_rdata);
            state    <= S_FETCH;
          end
        end
`endif
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpu.sv
// Directed testbench for pcpu with a wait-state memory model.
module tb_pcpu;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_req, mem_we, mem_ack, out_valid, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, out_data;

  int errors = 0;
  int checks = 0;

  pcpu #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory model: image is loaded into mem while load is high.
  logic [7:0] image [256];
  logic [7:0] mem [256];
  logic       load = 1'b0;
  logic       hold_writes = 1'b0;
  int         delay_max = 0;
  int         cnt = 0;
  int         need = 0;
  int         wr_cnt = 0;
  logic [7:0] last_waddr = 8'h00;
  logic [7:0] last_wdata = 8'h00;

  assign mem_ack   = mem_req && (cnt >= need) && !(hold_writes && mem_we);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= image[i];
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_waddr    <= mem_addr;
      last_wdata    <= mem_wdata;
    end
    if (load) begin
      cnt  <= 0;
      need <= 0;
    end else if (reset || !mem_req) begin
      cnt <= 0;
    end else if (mem_ack) begin
      cnt  <= 0;
      need <= int'($urandom_range(delay_max, 0));
    end else begin
      cnt <= cnt + 1;
    end
  end

  // Output and request-stability monitor.
  int         out_cnt = 0;
  int         stab_err = 0;
  int         stall_cnt = 0;
  logic [7:0] last_out = 8'h00;
  logic       pend = 1'b0;
  logic [7:0] p_addr = 8'h00;
  logic [7:0] p_wdata = 8'h00;
  logic       p_we = 1'b0;

  always @(negedge clk) begin
    if (out_valid) begin
      out_cnt  <= out_cnt + 1;
      last_out <= out_data;
    end
    if (pend && mem_req && (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we))
      stab_err <= stab_err + 1;
    if (mem_req && !mem_ack) stall_cnt <= stall_cnt + 1;
    pend    <= mem_req && !mem_ack;
    p_addr  <= mem_addr;
    p_wdata <= mem_wdata;
    p_we    <= mem_we;
  end

  task automatic clear_image();
    for (int i = 0; i < 256; i++) image[i] = 8'h0F;
  endtask

  task automatic start(input int dmax);
    reset = 1'b1;
    hold_writes = 1'b0;
    delay_max = dmax;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    clear_image();
    reset = 1'b1;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0h expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0h expected 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr got %0h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata got %0h expected 0", mem_wdata); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %0h expected 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h expected 0", out_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0h expected 0", halted); end
    checks++; if (dut.pc !== 8'h00 || dut.a !== 8'h00 || dut.b !== 8'h00) begin
      errors++; $display("FAIL rst_regs got pc=%0h a=%0h b=%0h expected 0", dut.pc, dut.a, dut.b); end
    checks++; if (dut.z !== 1'b0 || dut.c !== 1'b0) begin
      errors++; $display("FAIL rst_flags got z=%0h c=%0h expected 0", dut.z, dut.c); end
`ifdef PCPU_STACK_EN
    checks++; if (dut.sp !== 8'hFF) begin errors++; $display("FAIL rst_sp got %0h expected ff", dut.sp); end
`endif
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL first_fetch got req=%0h we=%0h addr=%0h expected 1 0 0", mem_req, mem_we, mem_addr); end
  endtask

  task automatic load_first_prog();
    clear_image();
    image[0] = 8'h01; image[1] = 8'h10;
    image[2] = 8'h02; image[3] = 8'h11;
    image[4] = 8'h03;
    image[5] = 8'h06;
    image[6] = 8'h0F;
    image[8'h10] = 8'h05;
    image[8'h11] = 8'h07;
  endtask

  task automatic test_basic();
    int cyc;
    int o0;
    load_first_prog();
    start(0);
    o0 = out_cnt;
    wait_halt(cyc);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halted got %0h expected 1", halted); end
    checks++; if (cyc !== 15) begin errors++; $display("FAIL basic_cycles got %0d expected 15", cyc); end
    checks++; if (out_cnt - o0 !== 1) begin errors++; $display("FAIL basic_out_pulses got %0d expected 1", out_cnt - o0); end
    checks++; if (last_out !== 8'h0C) begin errors++; $display("FAIL basic_out_data got %0h expected 0c", last_out); end
    checks++; if (dut.z !== 1'b0 || dut.c !== 1'b0) begin
      errors++; $display("FAIL basic_flags got z=%0h c=%0h expected 0 0", dut.z, dut.c); end
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL basic_halt_idle got req=%0h halted=%0h expected 0 1", mem_req, halted); end
  endtask

  task automatic test_carry_jump();
    int cyc;
    int o0;
    clear_image();
    image[0] = 8'h01; image[1] = 8'h50;
    image[2] = 8'h02; image[3] = 8'h51;
    image[4] = 8'h03;
    image[5] = 8'h0A; image[6] = 8'h20;
    image[8'h20] = 8'h09; image[8'h21] = 8'h40;
    image[8'h22] = 8'h08; image[8'h23] = 8'h30;
    image[8'h30] = 8'h06;
    image[8'h50] = 8'hFF; image[8'h51] = 8'h01;
    start(0);
    o0 = out_cnt;
    wait_halt(cyc);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL cj_halted got %0h expected 1", halted); end
    checks++; if (dut.a !== 8'h00) begin errors++; $display("FAIL cj_a got %0h expected 00", dut.a); end
    checks++; if (dut.c !== 1'b1) begin errors++; $display("FAIL cj_carry got %0h expected 1", dut.c); end
    checks++; if (dut.z !== 1'b1) begin errors++; $display("FAIL cj_zero got %0h expected 1", dut.z); end
    checks++; if (dut.pc !== 8'h32) begin errors++; $display("FAIL cj_path_pc got %0h expected 32", dut.pc); end
    checks++; if (out_cnt - o0 !== 1) begin errors++; $display("FAIL cj_out_pulses got %0d expected 1", out_cnt - o0); end
  endtask

  task automatic test_sub_store();
    int cyc;
    int w0;
    clear_image();
    image[0] = 8'h01; image[1] = 8'h60;
    image[2] = 8'h02; image[3] = 8'h61;
    image[4] = 8'h04;
    image[5] = 8'h05; image[6] = 8'h40;
    image[8'h40] = 8'h00;
    image[8'h60] = 8'h03; image[8'h61] = 8'h05;
    start(0);
    w0 = wr_cnt;
    wait_halt(cyc);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL sub_halted got %0h expected 1", halted); end
    checks++; if (dut.a !== 8'hFE) begin errors++; $display("FAIL sub_a got %0h expected fe", dut.a); end
    checks++; if (dut.c !== 1'b1) begin errors++; $display("FAIL sub_borrow got %0h expected 1", dut.c); end
    checks++; if (dut.z !== 1'b0) begin errors++; $display("FAIL sub_zero got %0h expected 0", dut.z); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL sta_writes got %0d expected 1", wr_cnt - w0); end
    checks++; if (last_waddr !== 8'h40 || last_wdata !== 8'hFE) begin
      errors++; $display("FAIL sta_write got addr=%0h data=%0h expected 40 fe", last_waddr, last_wdata); end
    checks++; if (mem[8'h40] !== 8'hFE) begin errors++; $display("FAIL sta_mem got %0h expected fe", mem[8'h40]); end
  endtask

  task automatic test_wait_states();
    int cyc;
    int o0, s0, st0;
    load_first_prog();
    start(3);
    o0 = out_cnt; s0 = stab_err; st0 = stall_cnt;
    wait_halt(cyc);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ws_halted got %0h expected 1", halted); end
    checks++; if (out_cnt - o0 !== 1) begin errors++; $display("FAIL ws_out_pulses got %0d expected 1", out_cnt - o0); end
    checks++; if (last_out !== 8'h0C) begin errors++; $display("FAIL ws_out_data got %0h expected 0c", last_out); end
    checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL ws_stable got %0d changes expected 0", stab_err - s0); end
    checks++; if (stall_cnt - st0 <= 0) begin errors++; $display("FAIL ws_stalled got %0d stall cycles expected >0", stall_cnt - st0); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ws_req_idle got %0h expected 0", mem_req); end
  endtask

`ifdef PCPU_STACK_EN
  task automatic test_call_ret();
    int cyc;
    int w0;
    logic found;
    clear_image();
    image[0] = 8'h0B; image[1] = 8'h50;
    image[2] = 8'h0F;
    image[8'h50] = 8'h0C;
    start(0);
    w0 = wr_cnt;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 8'h50) found = 1'b1;
    end
    checks++; if (found !== 1'b1 || dut.sp !== 8'hFE) begin
      errors++; $display("FAIL call_sp got found=%0h sp=%0h expected 1 fe", found, dut.sp); end
    wait_halt(cyc);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL call_writes got %0d expected 1", wr_cnt - w0); end
    checks++; if (last_waddr !== 8'hFF || last_wdata !== 8'h02) begin
      errors++; $display("FAIL call_push got addr=%0h data=%0h expected ff 02", last_waddr, last_wdata); end
    checks++; if (dut.sp !== 8'hFF) begin errors++; $display("FAIL ret_sp got %0h expected ff", dut.sp); end
    checks++; if (halted !== 1'b1 || dut.pc !== 8'h03) begin
      errors++; $display("FAIL ret_pc got halted=%0h pc=%0h expected 1 03", halted, dut.pc); end
  endtask
`else
  task automatic test_call_ret();
    int cyc;
    int w0, o0;
    clear_image();
    image[0] = 8'h01; image[1] = 8'h70;
    image[2] = 8'h0B;
    image[3] = 8'h06;
    image[4] = 8'h0C;
    image[5] = 8'h0F;
    image[8'h70] = 8'h5A;
    start(0);
    w0 = wr_cnt; o0 = out_cnt;
    wait_halt(cyc);
    checks++; if (halted !== 1'b1 || dut.pc !== 8'h06) begin
      errors++; $display("FAIL nostack_pc got halted=%0h pc=%0h expected 1 06", halted, dut.pc); end
    checks++; if (out_cnt - o0 !== 1 || last_out !== 8'h5A) begin
      errors++; $display("FAIL nostack_out got n=%0d data=%0h expected 1 5a", out_cnt - o0, last_out); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL nostack_writes got %0d expected 0", wr_cnt - w0); end
  endtask
`endif

  task automatic test_reset_mid_access();
    logic found;
    clear_image();
    image[0] = 8'h05; image[1] = 8'h40;
    image[8'h40] = 8'h33;
    start(0);
    hold_writes = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1'b1;
    end
    checks++; if (found !== 1'b1 || mem_addr !== 8'h40) begin
      errors++; $display("FAIL mid_sta_issue got found=%0h addr=%0h expected 1 40", found, mem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL mid_stalled got req=%0h we=%0h expected 1 1", mem_req, mem_we); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset_drop got req=%0h we=%0h expected 0 0", mem_req, mem_we); end
    @(negedge clk);
    hold_writes = 1'b0;
    @(negedge clk);
    checks++; if (mem[8'h40] !== 8'h33) begin errors++; $display("FAIL mid_no_write got %0h expected 33", mem[8'h40]); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL mid_refetch got req=%0h we=%0h addr=%0h expected 1 0 0", mem_req, mem_we, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_jump();
    test_sub_store();
    test_wait_states();
    test_call_ret();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcpu.md
# pcpu

Parametrised single-clock accumulator CPU core, successor to the 8-bit three-phase CPU. Replaces the derived cycle, memory and internal clocks with one clock and a request/acknowledge memory port that tolerates wait states. Adds generic data and address widths, a carry flag with conditional jump, a registered output port, and an optional hardware stack for CALL/RET. Sits between the top-level testbench or SoC glue and a single-ported program/data RAM.

## Interface
- DATA_W, 8, data word width; must be ≥ 8; opcode is the low 8 bits of the instruction word.
- ADDR_W, 8, address width; operand addresses are the low ADDR_W bits of the operand word.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  access address; stable while mem_req=1.
- mem_wdata  out  DATA_W  write data; stable while mem_req=1.
- mem_ack  in  1  access accepted; read data valid in the same cycle.
- mem_rdata  in  DATA_W  read data.
- out_data  out  DATA_W  last value written by OUT.
- out_valid  out  1  one-cycle pulse per OUT.
- halted  out  1  high from the HLT execution until reset.

## Operation
- Registers: A, B (DATA_W), IR (8), PC (ADDR_W), flags Z and C, SP (ADDR_W, stack builds only).
- Opcodes: 00 NOP; 01 LDA a (A←M[a]); 02 LDB a (B←M[a]); 03 ADD (A←A+B); 04 SUB (A←A−B); 05 STA a (M[a]←A); 06 OUT (out_data←A); 07 JMP a; 08 JEZ a; 09 JNZ a; 0A JC a; 0B CALL a; 0C RET; 0F HLT. Any other opcode executes as NOP.
- Opcodes with operand `a` occupy two words: the opcode word, then the operand word. PC increments past both, including for untaken jumps.
- Flags: Z ← (new A == 0) whenever A is written by LDA, ADD, or SUB. C ← carry-out of ADD, or borrow (A<B unsigned) for SUB. C is unchanged by LDA. B, STA, and OUT leave the flags unchanged.
- Arithmetic is modulo 2^DATA_W. PC and SP wrap modulo 2^ADDR_W with no fault.
- FSM states:
  - FETCH: read M[PC]; on ack IR←rdata[7:0], PC+1 → DECODE.
  - DECODE: no-operand ALU/OUT/HLT/NOP execute here → FETCH, or HALT for HLT; operand opcodes → OPND.
  - OPND: read M[PC]; on ack latch address, PC+1 → MEM (LDA/LDB/STA), JUMP, or PUSH (CALL).
  - MEM: read or write M[addr] → FETCH.
  - JUMP: PC←addr if the condition holds → FETCH.
  - PUSH: write PC to M[SP], SP−1, PC←addr → FETCH.
  - POP: SP+1 then read M[SP+1]; on ack PC←rdata → FETCH.
  - HALT: terminal; holds until reset.
- Only one access is outstanding at a time. mem_req drops in the cycle after ack unless the next state issues another access.
- HALT: mem_req=0, halted=1, all registers frozen, inputs ignored.

## Timing
- Reset values: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, out_data 0, out_valid 0, halted 0. A, B, IR, PC, Z, C are 0; SP is all-ones.
- First mem_req (read, addr 0) in the first clock after reset deasserts.
- Zero-wait cycle counts (ack in request cycle):
  - 2 cycles: NOP, ADD, SUB, OUT.
  - 4 cycles: LDA, LDB, STA, jumps, CALL.
  - 3 cycles: RET.
  - Each wait cycle adds 1.
- out_valid pulses in the DECODE cycle following OUT's fetch; out_data updates on the same edge.
- mem_ack while mem_req=0 is ignored.
- Reset asserted mid-access drops mem_req and mem_we combinationally-from-register on the reset assertion, with no completion of the pending write.

## Configuration
- PCPU_STACK_EN defined: SP register present; CALL pushes the return address (address after the operand word) at M[SP], post-decrement. RET pre-increments SP and reads the return address. No overflow or underflow detection; SP wraps.
- PCPU_STACK_EN undefined: no SP; CALL and RET decode as NOPs. CALL is still treated as a single-word NOP (operand word fetched as the next instruction).

## Test plan
- Program LDA 10, LDB 11, ADD, OUT, HLT with M[10]=0x05, M[11]=0x07, zero-wait -> out_valid once with out_data 0x0C, Z=0, C=0, then halted=1 and mem_req=0.
- ADD 0xFF+0x01 then JC 0x20 and JEZ 0x30 -> A=0x00, C=1, Z=1; PC takes 0x20; JNZ at 0x20 not taken.
- SUB 0x03−0x05 -> A=0xFE, C=1 (borrow), Z=0; STA 0x40 writes 0xFE with mem_we=1.
- Random 0–3 cycle ack delays on the first program -> identical out_data; mem_addr/mem_wdata/mem_we never change while mem_req=1 and unacked.
- PCPU_STACK_EN: CALL 0x50 at address 0x00, RET at 0x50 -> write of 0x02 to 0xFF, SP=0xFE, next fetch at 0x02, SP back to 0xFF.
- Reset asserted during a stalled STA -> mem_req/mem_we 0 immediately; after release, fetch from address 0.
